if_pc_gen: RTL and testbench
============================

Name: if_pc_gen

Overview:
Parametrised program-counter generator for the IF stage. It replaces the plain PC register with a block that has:
- a configurable reset vector;
- self-increment;
- a stall/handshake toward instruction memory;
- branch redirect and trap-vector entry with fixed priority;
- misalignment detection with a halt state.

It sits between the EX/MEM redirect logic and the instruction-memory address port, and feeds pc_out into the IF/ID pipeline register.

Parameters:
- XLEN, 32, width of the PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must be aligned to INSTR_BYTES.
- INSTR_BYTES, 4, instruction size in bytes. Must be a power of 2 (2 or 4). Sets the increment and the alignment mask.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold. The PC does not advance while high.
- fetch_ready  in  1  instruction memory can accept an address this cycle.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_target  in  XLEN  branch/jump target address.
- trap_valid  in  1  exception/trap entry request.
- trap_vector  in  XLEN  trap handler address. Low alignment bits are forced to 0 internally.
- pc_out  out  XLEN  registered current fetch address.
- pc_plus  out  XLEN  combinational pc_out + INSTR_BYTES, for link-register use.
- fetch_valid  out  1  pc_out is a valid fetch request.
- misaligned  out  1  sticky flag: a misaligned redirect was received.

Behaviour:
- Reset: synchronous, active-high, highest priority. On the first edge with reset high:
  - pc_out = RESET_VECTOR;
  - state = BOOT;
  - fetch_valid = 0;
  - misaligned = 0.
  - Reset asserted mid-operation overrides everything, including a same-cycle trap or redirect.
- Alignment: ALIGN_BITS = log2(INSTR_BYTES). An address is aligned iff addr[ALIGN_BITS-1:0] == 0.
- Fetch fire: fire = fetch_valid & fetch_ready & ~stall.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - fetch_valid = 0; pc_out holds RESET_VECTOR.
  - Unconditionally moves to RUN on the next edge, so the first fetch starts one cycle after reset deassertion.
- RUN: fetch_valid = 1. Next-PC priority, highest first:
  - trap_valid: pc_out <= trap_vector with low ALIGN_BITS cleared; state stays RUN.
  - redirect_valid with an aligned target: pc_out <= redirect_target.
  - redirect_valid with a misaligned target: pc_out <= redirect_target (kept for debug); misaligned <= 1; state <= HALT.
  - ~fire (stall or ~fetch_ready): pc_out holds.
  - otherwise: pc_out <= pc_out + INSTR_BYTES.
  - Redirect and trap take effect regardless of stall/fetch_ready. The flush is owned by the hazard unit.
- HALT:
  - fetch_valid = 0; pc_out holds.
  - redirect_valid is ignored.
  - trap_valid: pc_out <= aligned trap_vector; misaligned <= 0; state <= RUN.
  - Only reset or a trap leaves HALT.
- Arithmetic: the increment is modulo 2^XLEN. A PC of 2^XLEN - INSTR_BYTES increments to 0, with no flag.
- pc_plus is purely combinational from pc_out and uses the same wrap rule.
- Latency: redirect/trap accepted on edge N gives the new pc_out valid in the cycle after edge N. Zero bubbles inside this block.
- Simultaneous trap and redirect: the trap wins and the redirect is dropped.
- Outputs never show X after the first reset edge.

Decomposition:
- Package if_pkg:
  - pc_state_t enum {BOOT, RUN, HALT};
  - function align_bits(INSTR_BYTES);
  - localparam DEFAULT_RESET_VECTOR.
- No sub-module is needed. The next-PC mux plus the state register form a single always block with a separate combinational next-state block.
- Optional helper pc_align_check (combinational) only if it is reused by the ID-stage jump logic.

Test Plan:
- Reset, then idle with fetch_ready=1, stall=0, RESET_VECTOR=0 -> fetch_valid=0 for 1 cycle, then pc_out = 0, 4, 8, 12 on consecutive cycles.
- stall=1 for 3 cycles at pc_out=0x10 -> pc_out stays 0x10 and fetch_valid=1; stall releases -> 0x14 next cycle. Repeat with fetch_ready=0 -> same hold.
- redirect_valid=1, target=0x200, asserted while stall=1 -> pc_out=0x200 next cycle. Redirect with target 0x202 -> misaligned=1, fetch_valid=0, state HALT. Further redirects are ignored.
- In HALT, trap_valid=1 with trap_vector=0x8000_0003 -> pc_out=0x8000_0000, misaligned=0, fetch_valid=1, then increments to 0x8000_0004.
- Same-cycle trap (0x100) and redirect (0x300) -> pc_out=0x100. pc_out=0xFFFF_FFFC with fire -> pc_out=0x0000_0000, and pc_plus=0x0000_0000 before the edge.
- Reset asserted mid-run and coincident with trap_valid -> pc_out=RESET_VECTOR, BOOT entered. Rerun with INSTR_BYTES=2 and RESET_VECTOR=0x1000 -> sequence 0x1000, 0x1002; target 0x1001 flagged misaligned.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and helpers for the IF-stage program-counter generator.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package if_pkg;

    // BOOT: one dead cycle after reset, RUN: fetching, HALT: parked on a bad redirect
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Number of low address bits that must be zero for an aligned instruction.
    function automatic int align_bits(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Program-counter generator: reset vector, increment, redirect/trap entry, misalign halt.
// Latency: redirect/trap sampled on edge N drives pc_out right after edge N; no bubbles.
// Backpressure: PC holds while stall is high or fetch_ready is low; redirect/trap still apply.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall, fetch_ready  hazard hold and instruction-memory accept
//   redirect_valid/_target, trap_valid/trap_vector   next-PC overrides (trap wins)
//   pc_out, pc_plus     registered fetch address and its successor
//   fetch_valid         pc_out is a live fetch request (RUN state only)
//   misaligned          sticky flag set by a misaligned redirect, cleared by a trap
module if_pc_gen
    import if_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            misaligned
);

    localparam int              ALIGN_BITS = align_bits(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << ALIGN_BITS) - 1);
    localparam logic [XLEN-1:0] PC_INCR    = XLEN'(INSTR_BYTES);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            mis_nxt;
    logic            fire;
    logic            target_misaligned;
    logic [XLEN-1:0] trap_target;

    assign fetch_valid       = (state == RUN);
    assign fire              = fetch_valid & fetch_ready & ~stall;
    // Natural XLEN-bit overflow gives the required wrap to zero.
    assign pc_plus           = pc_out + PC_INCR;
    assign target_misaligned = |(redirect_target & ALIGN_MASK);
    // Trap handlers are always entered on an instruction boundary.
    assign trap_target       = trap_vector & ~ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            pc_out     <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_out     <= pc_nxt;
            misaligned <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
        mis_nxt   = misaligned;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (trap_valid) begin
                    pc_nxt = trap_target;
                end else if (redirect_valid) begin
                    // Misaligned target is still latched so a debugger can see it.
                    pc_nxt = redirect_target;
                    if (target_misaligned) begin
                        mis_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end else if (fire) begin
                    pc_nxt = pc_plus;
                end
            end
            HALT: begin
                // Redirects are ignored here; only a trap (or reset) recovers.
                if (trap_valid) begin
                    pc_nxt    = trap_target;
                    mis_nxt   = 1'b0;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: two instances (4-byte/reset 0, 2-byte/reset 0x1000) driven
// by directed vector tables; each vector carries the outputs expected in that cycle.
// A negedge monitor pops expected entries and compares them with the DUT outputs.
module tb_if_pc_gen;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tvec;
        bit          chk;
        logic [31:0] pc;
        logic        fv;
        logic        mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        stall [2];
    logic        rdy [2];
    logic        rv [2];
    logic [31:0] rt [2];
    logic        tv [2];
    logic [31:0] tvec [2];
    logic [31:0] pc_o [2];
    logic [31:0] pcp_o [2];
    logic        fv_o [2];
    logic        mis_o [2];

    vec_t tbl [2][$];
    vec_t expq [2][$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .INSTR_BYTES(4)) dut (
        .clk(clk), .reset(rst[0]), .stall(stall[0]), .fetch_ready(rdy[0]),
        .redirect_valid(rv[0]), .redirect_target(rt[0]),
        .trap_valid(tv[0]), .trap_vector(tvec[0]),
        .pc_out(pc_o[0]), .pc_plus(pcp_o[0]), .fetch_valid(fv_o[0]), .misaligned(mis_o[0])
    );

    if_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .INSTR_BYTES(2)) dut2 (
        .clk(clk), .reset(rst[1]), .stall(stall[1]), .fetch_ready(rdy[1]),
        .redirect_valid(rv[1]), .redirect_target(rt[1]),
        .trap_valid(tv[1]), .trap_vector(tvec[1]),
        .pc_out(pc_o[1]), .pc_plus(pcp_o[1]), .fetch_valid(fv_o[1]), .misaligned(mis_o[1])
    );

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic v, input logic [31:0] t,
                                input logic tr, input logic [31:0] tve,
                                input bit c, input logic [31:0] p,
                                input logic f, input logic m);
        vec_t x;
        x.rst = r; x.stall = s; x.rdy = rd; x.rv = v; x.rt = t;
        x.tv = tr; x.tvec = tve; x.chk = c; x.pc = p; x.fv = f; x.mis = m;
        return x;
    endfunction

    task automatic check(input int d, input int cyc, input string name,
                         input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL dut%0d cycle %0d %s: got %h expected %h", d, cyc, name, got, exp);
        end
    endtask

    task automatic drive(input int d);
        for (int i = 0; i < tbl[d].size(); i++) begin
            vec_t v;
            v = tbl[d][i];
            @(posedge clk);
            #1;
            rst[d]   = v.rst;
            stall[d] = v.stall;
            rdy[d]   = v.rdy;
            rv[d]    = v.rv;
            rt[d]    = v.rt;
            tv[d]    = v.tv;
            tvec[d]  = v.tvec;
            if (v.chk) expq[d].push_back(v);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    int mon_cyc = 0;
    always @(negedge clk) begin : monitor
        vec_t e;
        logic [31:0] inc;
        mon_cyc++;
        for (int d = 0; d < 2; d++) begin
            if (expq[d].size() > 0) begin
                e   = expq[d].pop_front();
                inc = (d == 0) ? 32'd4 : 32'd2;
                check(d, mon_cyc, "pc_out",      pc_o[d],          e.pc);
                check(d, mon_cyc, "pc_plus",     pcp_o[d],         e.pc + inc);
                check(d, mon_cyc, "fetch_valid", {31'd0, fv_o[d]}, {31'd0, e.fv});
                check(d, mon_cyc, "misaligned",  {31'd0, mis_o[d]}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; stall[d] = 1'b0; rdy[d] = 1'b1; rv[d] = 1'b0;
            rt[d] = '0; tv[d] = 1'b0; tvec[d] = '0;
        end

        // Instance 0: 4-byte instructions, reset vector 0.
        //              rst stl rdy rv  target         tv  tvec           chk exp_pc         fv  mis
        tbl[0].push_back(mk(1, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hC,         1, 0));
        tbl[0].push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,        1, 0));
        tbl[0].push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,        1, 0));
        tbl[0].push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,        1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,        1, 0));
        tbl[0].push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h14,        1, 0));
        tbl[0].push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h14,        1, 0));
        tbl[0].push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h14,        1, 0));
        tbl[0].push_back(mk(0, 1, 1, 1, 32'h200,       0, 32'h0,         1, 32'h14,        1, 0));
        tbl[0].push_back(mk(0, 0, 1, 1, 32'h202,       0, 32'h0,         1, 32'h200,       1, 0));
        tbl[0].push_back(mk(0, 0, 1, 1, 32'h400,       0, 32'h0,         1, 32'h202,       0, 1));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h202,       0, 1));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         1, 32'h8000_0003, 1, 32'h202,       0, 1));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0000, 1, 0));
        tbl[0].push_back(mk(0, 0, 1, 1, 32'h300,       1, 32'h100,       1, 32'h8000_0004, 1, 0));
        tbl[0].push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         1, 32'h100,       1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0));
        tbl[0].push_back(mk(1, 0, 1, 0, 32'h0,         1, 32'h500,       1, 32'h4,         1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0));
        tbl[0].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         1, 0));

        // Instance 1: 2-byte instructions, reset vector 0x1000.
        tbl[1].push_back(mk(1, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0));
        tbl[1].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h1000,      0, 0));
        tbl[1].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h1000,      1, 0));
        tbl[1].push_back(mk(0, 0, 1, 1, 32'h1001,      0, 32'h0,         1, 32'h1002,      1, 0));
        tbl[1].push_back(mk(0, 0, 1, 0, 32'h0,         1, 32'h2003,      1, 32'h1001,      0, 1));
        tbl[1].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h2002,      1, 0));
        tbl[1].push_back(mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h2004,      1, 0));

        fork
            drive(0);
            drive(1);
        join
        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (expq[d].size() != 0) begin
                n_fail++;
                $display("FAIL dut%0d drain: %0d expectations left unchecked, required 0", d, expq[d].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
